// File: rtl/fsic_axis_rx_fifo.sv
// fsic_axis_rx_fifo: FWFT receive buffer between io serdes RX and the axis switch
// Ports: is_as_* beats from io serdes (no backpressure), as_is_tready threshold
// flow-control bit back to the serdes, m_axis_* AXI-Stream master (FIFO head),
// fifo_count occupancy, ovf_flag sticky drop indicator cleared by ovf_clr.
module fsic_axis_rx_fifo #(
   parameter int pDATA_WIDTH = 32,
   parameter int pFIFO_DEPTH = 8,
   parameter int pTHRESHOLD  = 3
) (
   input  logic                             axis_clk,
   input  logic                             axis_rst_n,
   input  logic [pDATA_WIDTH-1:0]           is_as_tdata,
   input  logic [pDATA_WIDTH/8-1:0]         is_as_tstrb,
   input  logic [pDATA_WIDTH/8-1:0]         is_as_tkeep,
   input  logic                             is_as_tlast,
   input  logic [1:0]                       is_as_tid,
   input  logic [1:0]                       is_as_tuser,
   input  logic                             is_as_tvalid,
   output logic                             as_is_tready,
   output logic [pDATA_WIDTH-1:0]           m_axis_tdata,
   output logic [pDATA_WIDTH/8-1:0]         m_axis_tstrb,
   output logic [pDATA_WIDTH/8-1:0]         m_axis_tkeep,
   output logic                             m_axis_tlast,
   output logic [1:0]                       m_axis_tid,
   output logic [1:0]                       m_axis_tuser,
   output logic                             m_axis_tvalid,
   input  logic                             m_axis_tready,
   output logic [$clog2(pFIFO_DEPTH+1)-1:0] fifo_count,
   output logic                             ovf_flag,
   input  logic                             ovf_clr
);
   localparam int SW = pDATA_WIDTH / 8;
   localparam int AW = $clog2(pFIFO_DEPTH);
   localparam int CW = $clog2(pFIFO_DEPTH + 1);
   localparam int EW = 5 + 2 * SW + pDATA_WIDTH;

   logic [EW-1:0] mem_q [pFIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d, rdy_q, rdy_d;
   logic          pop, push, drop;
   logic [EW-1:0] head;

   assign pop     = (count_q != '0) && m_axis_tready;
   // a full FIFO still accepts a beat when the head leaves in the same cycle
   assign push    = is_as_tvalid && ((int'(count_q) < pFIFO_DEPTH) || pop);
   assign drop    = is_as_tvalid && !push;
   assign count_d = count_q + CW'(push) - CW'(pop);
   assign ovf_d   = drop || (ovf_q && !ovf_clr);
   assign rdy_d   = int'(count_d) < pFIFO_DEPTH - pTHRESHOLD;
   assign head    = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

   assign {m_axis_tlast, m_axis_tid, m_axis_tuser, m_axis_tkeep, m_axis_tstrb, m_axis_tdata} = head;
   assign m_axis_tvalid = count_q != '0;
   assign fifo_count    = count_q;
   assign ovf_flag      = ovf_q;
   assign as_is_tready  = rdy_q;

   // storage needs no reset: output is gated by occupancy
   always_ff @(posedge axis_clk)
      if (push)
         mem_q[wr_ptr_q] <= {is_as_tlast, is_as_tid, is_as_tuser, is_as_tkeep, is_as_tstrb, is_as_tdata};

   always_ff @(posedge axis_clk or negedge axis_rst_n)
      if (!axis_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         rdy_q    <= 1'b0;
      end else begin
         wr_ptr_q <= push ? wr_ptr_q + AW'(1) : wr_ptr_q;
         rd_ptr_q <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         rdy_q    <= rdy_d;
      end
endmodule

// File: tb/tb_fsic_axis_rx_fifo.sv
// tb_fsic_axis_rx_fifo: self-checking bench comparing the FIFO against a queue model
module tb_fsic_axis_rx_fifo;
   localparam int DW = 32, D = 8, T = 3;

   typedef struct packed {
      logic        l;
      logic [1:0]  id;
      logic [1:0]  u;
      logic [3:0]  k;
      logic [3:0]  s;
      logic [31:0] d;
   } beat_t;

   logic          clk = 0, rst_n = 0;
   logic [DW-1:0] is_tdata = '0;
   logic [3:0]    is_tstrb = '0, is_tkeep = '0;
   logic          is_tlast = 0, is_tvalid = 0;
   logic [1:0]    is_tid = '0, is_tuser = '0;
   logic          as_is_tready, m_tvalid, m_tlast, ovf_flag;
   logic          m_tready = 0, ovf_clr = 0;
   logic [DW-1:0] m_tdata;
   logic [3:0]    m_tstrb, m_tkeep, fifo_count;
   logic [1:0]    m_tid, m_tuser;
   logic [51:0]   obs;

   beat_t mq[$];
   bit    m_ovf, m_rdy;
   int    n_cmp = 0, n_fail = 0;

   fsic_axis_rx_fifo #(.pDATA_WIDTH(DW), .pFIFO_DEPTH(D), .pTHRESHOLD(T)) dut (
      .axis_clk(clk), .axis_rst_n(rst_n),
      .is_as_tdata(is_tdata), .is_as_tstrb(is_tstrb), .is_as_tkeep(is_tkeep),
      .is_as_tlast(is_tlast), .is_as_tid(is_tid), .is_as_tuser(is_tuser),
      .is_as_tvalid(is_tvalid), .as_is_tready(as_is_tready),
      .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tkeep(m_tkeep),
      .m_axis_tlast(m_tlast), .m_axis_tid(m_tid), .m_axis_tuser(m_tuser),
      .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .fifo_count(fifo_count), .ovf_flag(ovf_flag), .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;

   assign obs = {m_tvalid, fifo_count, ovf_flag, as_is_tready,
                 m_tlast, m_tid, m_tuser, m_tkeep, m_tstrb, m_tdata};

   function automatic logic [51:0] expv();
      beat_t h;
      h = (mq.size() != 0) ? mq[0] : '0;
      return {mq.size() != 0, 4'(mq.size()), m_ovf, m_rdy, h};
   endfunction

   function automatic beat_t rb();
      beat_t b;
      b = {$urandom, $urandom};
      return b;
   endfunction

   function automatic beat_t mk(input logic [31:0] d);
      beat_t b;
      b = rb();
      b.d = d;
      return b;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_ovf = 0;
      m_rdy = 0;
   endtask

   // drive one cycle of inputs, advance past the edge, then advance the model
   task automatic cycle(input bit v, input beat_t b, input bit r, input bit c);
      bit pop, drop;
      {is_tlast, is_tid, is_tuser, is_tkeep, is_tstrb, is_tdata} = b;
      is_tvalid = v;
      m_tready = r;
      ovf_clr = c;
      pop = mq.size() != 0 && r;
      drop = v && mq.size() == D && !pop;
      @(posedge clk);
      #1;
      if (pop) void'(mq.pop_front());
      if (v && !drop) mq.push_back(b);
      m_ovf = drop || (m_ovf && !c);
      m_rdy = (D - mq.size()) > T;
   endtask

   task automatic test_reset();
      model_reset();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (obs !== expv()) begin n_fail++; $display("FAIL reset_hold: got %h want %h", obs, expv()); end
      rst_n = 1;
      #1;
      n_cmp++;
      if (obs !== expv()) begin n_fail++; $display("FAIL reset_release: got %h want %h", obs, expv()); end
      cycle(0, '0, 0, 0);
      n_cmp++;
      if (obs !== expv() || as_is_tready !== 1'b1)
         begin n_fail++; $display("FAIL ready_after_release: got %h want %h", obs, expv()); end
   endtask

   task automatic test_single();
      beat_t b;
      b = '{l:1'b1, id:2'd2, u:2'd1, k:4'hF, s:4'hF, d:32'hA5A5_0001};
      cycle(1, b, 1, 0);
      n_cmp++;
      if (obs !== expv() || m_tdata !== 32'hA5A5_0001 || m_tid !== 2'd2)
         begin n_fail++; $display("FAIL single_head: got %h want %h", obs, expv()); end
      cycle(0, '0, 1, 0);
      n_cmp++;
      if (obs !== expv() || fifo_count !== 4'd0)
         begin n_fail++; $display("FAIL single_drain: got %h want %h", obs, expv()); end
   endtask

   task automatic test_threshold();
      for (int i = 0; i < 5; i++) begin
         cycle(1, mk(32'h10 + i), 0, 0);
         n_cmp++;
         if (obs !== expv() || as_is_tready !== (i < 4))
            begin n_fail++; $display("FAIL thr_fill%0d: got %h want %h", i, obs, expv()); end
      end
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (obs !== expv() || m_tdata !== 32'h10 + i)
            begin n_fail++; $display("FAIL thr_drain%0d: got %h want %h", i, obs, expv()); end
         cycle(0, '0, 1, 0);
      end
      n_cmp++;
      if (obs !== expv() || as_is_tready !== 1'b1)
         begin n_fail++; $display("FAIL thr_empty: got %h want %h", obs, expv()); end
   endtask

   task automatic test_drop();
      for (int i = 0; i < D; i++) cycle(1, rb(), 0, 0);
      n_cmp++;
      if (obs !== expv() || fifo_count !== 4'd8)
         begin n_fail++; $display("FAIL drop_full: got %h want %h", obs, expv()); end
      cycle(1, mk(32'hDEAD), 0, 0);
      n_cmp++;
      if (obs !== expv() || ovf_flag !== 1'b1 || fifo_count !== 4'd8)
         begin n_fail++; $display("FAIL drop_ovf: got %h want %h", obs, expv()); end
      cycle(0, '0, 0, 1);
      n_cmp++;
      if (obs !== expv() || ovf_flag !== 1'b0)
         begin n_fail++; $display("FAIL ovf_clr: got %h want %h", obs, expv()); end
      cycle(1, mk(32'hDEAD), 0, 1);
      n_cmp++;
      if (obs !== expv() || ovf_flag !== 1'b1)
         begin n_fail++; $display("FAIL ovf_set_wins: got %h want %h", obs, expv()); end
      cycle(0, '0, 0, 1);
      for (int i = 0; i < D; i++) begin
         n_cmp++;
         if (obs !== expv() || m_tdata === 32'hDEAD)
            begin n_fail++; $display("FAIL drop_drain%0d: got %h want %h", i, obs, expv()); end
         cycle(0, '0, 1, 0);
      end
   endtask

   task automatic test_full_pushpop();
      for (int i = 0; i < D; i++) cycle(1, rb(), 0, 0);
      for (int i = 0; i < 4; i++) begin
         cycle(1, rb(), 1, 0);
         n_cmp++;
         if (obs !== expv() || fifo_count !== 4'd8 || ovf_flag !== 1'b0)
            begin n_fail++; $display("FAIL full_pushpop%0d: got %h want %h", i, obs, expv()); end
      end
      while (mq.size() != 0) begin
         n_cmp++;
         if (obs !== expv()) begin n_fail++; $display("FAIL full_drain: got %h want %h", obs, expv()); end
         cycle(0, '0, 1, 0);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 2) != 0, rb(), $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
         n_cmp++;
         if (obs !== expv()) begin n_fail++; $display("FAIL rand%0d: got %h want %h", i, obs, expv()); end
      end
      while (mq.size() != 0) cycle(0, '0, 1, 1);
   endtask

   task automatic test_midreset();
      for (int i = 0; i < 3; i++) cycle(1, rb(), 0, 0);
      #3;
      rst_n = 0;
      model_reset();
      #1;
      n_cmp++;
      if (obs !== expv() || m_tvalid !== 1'b0 || as_is_tready !== 1'b0)
         begin n_fail++; $display("FAIL mid_reset_async: got %h want %h", obs, expv()); end
      #2;
      rst_n = 1;
      cycle(0, '0, 1, 0);
      n_cmp++;
      if (obs !== expv() || fifo_count !== 4'd0 || m_tvalid !== 1'b0)
         begin n_fail++; $display("FAIL mid_reset_release: got %h want %h", obs, expv()); end
      cycle(1, mk(32'h5151), 0, 0);
      n_cmp++;
      if (obs !== expv() || m_tdata !== 32'h5151)
         begin n_fail++; $display("FAIL mid_reset_fresh: got %h want %h", obs, expv()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_threshold();
      test_drop();
      test_full_pushpop();
      test_random();
      test_midreset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/fsic_axis_rx_fifo.md
Name: fsic_axis_rx_fifo

Overview:
- Receive-side buffer in the axis switch, directly downstream of the io serdes RX path.
- Captures every beat presented on is_as_* (the io serdes has no per-beat backpressure) into a first-word-fall-through FIFO and replays it on a standard AXI-Stream master interface.
- Generates as_is_tready from a free-space threshold; the io serdes serialises this bit to the remote side as flow control.

Parameters:
- pDATA_WIDTH, 32, tdata width; tstrb/tkeep are pDATA_WIDTH/8.
- pFIFO_DEPTH, 8, number of entries; must be a power of two, at least 4.
- pTHRESHOLD, 3, as_is_tready deasserts when free entries <= pTHRESHOLD; covers serdes round-trip latency; must be < pFIFO_DEPTH.

Ports:
- axis_clk  in  1  core clock
- axis_rst_n  in  1  asynchronous active-low reset
- is_as_tdata  in  pDATA_WIDTH  received data from io serdes
- is_as_tstrb  in  pDATA_WIDTH/8  received strobe
- is_as_tkeep  in  pDATA_WIDTH/8  received keep
- is_as_tlast  in  1  received last
- is_as_tid  in  2  received id
- is_as_tuser  in  2  received user
- is_as_tvalid  in  1  beat present this cycle; no ready is returned to the source
- as_is_tready  out  1  flow-control bit to io serdes (remote-side permission to send)
- m_axis_tdata, m_axis_tstrb, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tuser  out  same widths as inputs  FIFO head beat
- m_axis_tvalid  out  1  head entry valid
- m_axis_tready  in  1  downstream accept
- fifo_count  out  $clog2(pFIFO_DEPTH+1)  current occupancy
- ovf_flag  out  1  sticky: a beat was dropped
- ovf_clr  in  1  synchronous clear of ovf_flag

Behaviour:
- Single clock domain: axis_clk; all state is reset asynchronously by axis_rst_n low.
- Reset values:
  - wr_ptr, rd_ptr, fifo_count = 0.
  - m_axis_tvalid = 0, as_is_tready = 0, ovf_flag = 0.
  - Payload outputs = 0 while empty.
- Storage: pFIFO_DEPTH entries. Each entry holds {tlast, tid, tuser, tkeep, tstrb, tdata}, 1+2+2+2*(pDATA_WIDTH/8)+pDATA_WIDTH bits. Pointers are log2(pFIFO_DEPTH) bits and wrap modulo depth.
- pop = m_axis_tvalid && m_axis_tready.
- push_req = is_as_tvalid.
- push = push_req && (fifo_count < pFIFO_DEPTH || pop). When full with a simultaneous pop, the push is accepted.
- Drop: push_req while full without pop. The beat is discarded, pointers are unchanged, and ovf_flag is set to 1 on the next edge.
- ovf_clr: clears ovf_flag. If a drop occurs in the same cycle, set wins.
- Count update: fifo_count_next = fifo_count + push - pop. Values are 0..pFIFO_DEPTH and must never wrap.
- Latency and output timing:
  - A beat pushed at edge N appears on m_axis_* with m_axis_tvalid=1 after edge N (the cycle after is_as_tvalid was sampled).
  - m_axis_tvalid = (fifo_count != 0).
  - Payload outputs are driven combinationally from mem[rd_ptr], zero when empty.
  - The head is held stable while m_axis_tvalid=1 and m_axis_tready=0.
- Push into an empty FIFO with m_axis_tready=1: no bypass. The beat is popped one cycle later.
- Flow control:
  - as_is_tready is a register.
  - as_is_tready <= ((pFIFO_DEPTH - fifo_count_next) > pTHRESHOLD).
  - After reset release it rises on the first edge (FIFO empty), so exactly one cycle after reset deassertion.
  - Example (depth 8, threshold 3): tready = 1 for count_next <= 4 and 0 for count_next >= 5.
- Reset mid-operation: contents are discarded immediately. m_axis_tvalid and as_is_tready drop to 0 asynchronously, and no stale beat is presented after release.
- Ordering: strict FIFO. tlast is carried per beat; packets are not re-framed.

Test Plan:
- Reset then release, no traffic -> as_is_tready=0 during reset and 1 one cycle after release; m_axis_tvalid=0; fifo_count=0; ovf_flag=0.
- Single beat tdata=0xA5A5_0001, tlast=1, tid=2, tuser=1, m_axis_tready=1 -> m_axis_tvalid=1 the cycle after push with identical fields; popped next edge; count returns to 0.
- m_axis_tready=0, push 5 beats (0x10..0x14), depth 8, threshold 3 -> as_is_tready goes 0 on the edge where count becomes 5; then ready=1 drains 0x10..0x14 in order; as_is_tready returns to 1 when count_next <= 4.
- Fill 8 beats, push a 9th (0xDEAD) with m_axis_tready=0 -> beat dropped, count stays 8, ovf_flag=1; ovf_clr pulse -> ovf_flag=0; 0xDEAD never appears on the output.
- Full FIFO, is_as_tvalid=1 and m_axis_tready=1 in the same cycle for 4 cycles -> no drop, count stays 8, ovf_flag stays 0, output order preserved.
- Assert axis_rst_n low with count=3 -> m_axis_tvalid=0 and as_is_tready=0 immediately; after release count=0 and no stale data is output.
